// File: rtl/booth_seq_mult_ctrl_if.sv
// booth_seq_mult_ctrl_if: start/busy/done handshake and operand/product bus for the Booth multiplier.
interface booth_seq_mult_ctrl_if #(parameter int WIDTH = 8);
    logic                 start;
    logic                 flush;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out_c;

    modport master (output start, flush, in_a, in_b, input busy, done, out_c);
    modport slave  (input start, flush, in_a, in_b, output busy, done, out_c);
endinterface

// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult_ctrl: sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock.
module booth_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_seq_mult_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d, q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic [WIDTH:0]       m_ext, sum, a_sh, q_sh;
    logic                 accept, last;

    // A carries one guard bit so A - (-2^(WIDTH-1)) cannot overflow
    always_comb begin
        m_ext   = {m_q[WIDTH-1], m_q};
        sum     = (q_q[1:0] == 2'b01) ? a_q + m_ext :
                  (q_q[1:0] == 2'b10) ? a_q - m_ext : a_q;
        a_sh    = {sum[WIDTH], sum[WIDTH:1]};
        q_sh    = {sum[0], q_q[WIDTH:1]};
        last    = cnt_q == CW'(WIDTH - 1);
        accept  = bus.start && !bus.flush && state_q != RUN;
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = RUN;
            m_d     = bus.in_b;
            q_d     = {bus.in_a, 1'b0};
            a_d     = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d   = a_sh;
            q_d   = q_sh;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                out_d   = {a_sh[WIDTH-1:0], q_sh[WIDTH:1]};
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy  = state_q == RUN;
    assign bus.done  = state_q == DONE;
    assign bus.out_c = out_q;
endmodule
